// File: rtl/handshake_const_arbiter.sv
// Round-robin arbiter that turns per-requester tokens into a registered
// constant. Each accepted token from requester i loads CONSTS slice i and
// the index i into a single output slot, drained by a valid/ready handshake.
//
// Ports:
//   clk         - clock, all state on the rising edge
//   rst         - asynchronous active-low reset
//   ctrl_valid  - per-requester token valid
//   ctrl_ready  - per-requester token accept (at most one bit set)
//   outs        - registered constant of the served requester
//   outs_id     - index of the served requester
//   outs_valid  - output slot full
//   outs_ready  - downstream accept
module handshake_const_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 4,
  parameter logic [NUM_REQ*DATA_WIDTH-1:0] CONSTS = '0,
  localparam int unsigned ID_W = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    ctrl_valid,
  output logic [NUM_REQ-1:0]    ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic [ID_W-1:0]       outs_id,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  logic [DATA_WIDTH-1:0] outs_q, outs_d;
  logic [ID_W-1:0]       outs_id_q, outs_id_d;
  logic                  outs_valid_q, outs_valid_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;

  logic                  slot_free;
  logic                  win_found;
  logic [ID_W-1:0]       win_idx;
  logic [ID_W:0]         scan_idx;
  logic                  accept;
  logic [DATA_WIDTH-1:0] const_sel;

  assign slot_free = !outs_valid_q || outs_ready;

  // Scan ptr, ptr+1, ... and wrap at NUM_REQ. The extra bit in scan_idx holds
  // ptr+k before the wrap so non-power-of-two counts never alias.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      scan_idx = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (scan_idx >= (ID_W+1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
      end
      if (!win_found && ctrl_valid[scan_idx[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[ID_W-1:0];
      end
    end
  end

  assign accept = win_found && slot_free;

  // Constant-index slice selection keeps the mux free of variable part-selects.
  always_comb begin
    const_sel = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (win_idx == ID_W'(i)) begin
        const_sel = CONSTS[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Ready is gated by rst so nothing is accepted while reset is held.
  always_comb begin
    ctrl_ready = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      ctrl_ready[i] = rst && accept && (win_idx == ID_W'(i));
    end
  end

  always_comb begin
    outs_d       = outs_q;
    outs_id_d    = outs_id_q;
    outs_valid_d = outs_valid_q;
    ptr_d        = ptr_q;
    if (accept) begin
      // Covers the simultaneous drain+fill case: no bubble.
      outs_d       = const_sel;
      outs_id_d    = win_idx;
      outs_valid_d = 1'b1;
      ptr_d        = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
    end else if (outs_valid_q && outs_ready) begin
      outs_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outs_q       <= '0;
      outs_id_q    <= '0;
      outs_valid_q <= 1'b0;
      ptr_q        <= '0;
    end else begin
      outs_q       <= outs_d;
      outs_id_q    <= outs_id_d;
      outs_valid_q <= outs_valid_d;
      ptr_q        <= ptr_d;
    end
  end

  assign outs       = outs_q;
  assign outs_id    = outs_id_q;
  assign outs_valid = outs_valid_q;

endmodule

// File: tb/tb_handshake_const_arbiter.sv
// Randomized and directed bench for handshake_const_arbiter with a queue-based
// scoreboard: the driver pushes each token the reference model accepts, and an
// independent monitor pops and compares whenever the DUT hands a token off.
module tb_handshake_const_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam logic [N*DW-1:0] CONSTS_P = {32'h13, 32'h12, 32'h11, 32'h10};

  logic          clk;
  logic          rst;
  logic [N-1:0]  ctrl_valid;
  logic [N-1:0]  ctrl_ready;
  logic [DW-1:0] outs;
  logic [1:0]    outs_id;
  logic          outs_valid;
  logic          outs_ready;

  handshake_const_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (N),
    .CONSTS     (CONSTS_P)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ctrl_valid (ctrl_valid),
    .ctrl_ready (ctrl_ready),
    .outs       (outs),
    .outs_id    (outs_id),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Scoreboard of accepted tokens awaiting hand-off.
  int          exp_id_q[$];
  logic [31:0] exp_data_q[$];

  // Reference model: slot contents and round-robin start point.
  int m_ptr   = 0;
  bit m_valid = 0;
  int m_id    = 0;
  int wait_cnt[N];
  int id1_seen;

  function automatic logic [31:0] const_of(input int id);
    return 32'h10 + 32'(id);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at the falling edge, check outputs 2ns later, then
  // advance the model to the state it should hold after the next rising edge.
  task automatic cycle(input logic [N-1:0] cv, input logic ordy);
    int          w;
    logic [N-1:0] exp_rdy;
    bit          free;
    int          mx;
    @(negedge clk);
    ctrl_valid = cv;
    outs_ready = ordy;
    #2;
    chk("outs_valid", 64'(outs_valid), 64'(m_valid));
    if (m_valid) begin
      chk("outs_id", 64'(outs_id), 64'(m_id));
      chk("outs", 64'(outs), 64'(const_of(m_id)));
    end
    free = !m_valid || ordy;
    w = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (w < 0 && cv[i]) w = i;
    end
    exp_rdy = (w >= 0 && free) ? N'(1 << w) : '0;
    chk("ctrl_ready", 64'(ctrl_ready), 64'(exp_rdy));
    // Fairness, judged from what the DUT actually granted.
    if (ctrl_ready != '0) begin
      mx = 0;
      for (int i = 0; i < N; i++) begin
        if (ctrl_ready[i] || !cv[i]) wait_cnt[i] = 0;
        else wait_cnt[i]++;
        if (wait_cnt[i] > mx) mx = wait_cnt[i];
      end
      chk("fairness", 64'(mx <= N), 64'(1));
    end else begin
      for (int i = 0; i < N; i++) if (!cv[i]) wait_cnt[i] = 0;
    end
    if (exp_rdy != '0) begin
      m_valid = 1;
      m_id    = w;
      m_ptr   = (w + 1) % N;
      exp_id_q.push_back(w);
      exp_data_q.push_back(const_of(w));
    end else if (m_valid && ordy) begin
      m_valid = 0;
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_valid = 0;
    m_id    = 0;
    exp_id_q.delete();
    exp_data_q.delete();
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
  endtask

  // Assert reset between clock edges and check the slot empties at once.
  task automatic pulse_reset();
    #4;
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_async_valid", 64'(outs_valid), 64'(0));
    chk("rst_async_ready", 64'(ctrl_ready), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: pops the scoreboard on every DUT output hand-off.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst && outs_valid && outs_ready) begin
        if (outs_valid && outs_id == 2'd1) id1_seen++;
        if (exp_id_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL sb_unexpected actual id=%0d required=none at %0t", outs_id, $time);
        end else begin
          chk("sb_id", 64'(outs_id), 64'(exp_id_q.pop_front()));
          chk("sb_data", 64'(outs), 64'(exp_data_q.pop_front()));
        end
      end
    end
  end

  initial begin
    id1_seen   = 0;
    rst        = 1'b0;
    ctrl_valid = '1;
    outs_ready = 1'b1;
    model_reset();
    #1;
    chk("reset_valid", 64'(outs_valid), 64'(0));
    chk("reset_outs", 64'(outs), 64'(0));
    chk("reset_id", 64'(outs_id), 64'(0));
    chk("reset_ready", 64'(ctrl_ready), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    ctrl_valid = '0;
    rst = 1'b1;

    // Single requester 2, then wrap-around from ptr=3 to requester 0.
    cycle(4'b0100, 1'b1);
    cycle(4'b0000, 1'b1);
    chk("d31_outs", 64'(outs), 64'(32'h12));
    chk("d31_id", 64'(outs_id), 64'(2));
    cycle(4'b0001, 1'b1);
    cycle(4'b0010, 1'b1);
    chk("d34_wrap_id", 64'(outs_id), 64'(0));
    chk("d34_ptr1", 64'(ctrl_ready), 64'(4'b0010));
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);

    // All requesters busy: strict rotation, no bubbles.
    pulse_reset();
    for (int j = 0; j < 9; j++) begin
      cycle((j < 8) ? 4'b1111 : 4'b0000, 1'b1);
      if (j > 0) begin
        chk("d32_valid", 64'(outs_valid), 64'(1));
        chk("d32_id", 64'(outs_id), 64'((j - 1) % 4));
      end
    end

    // Back-pressure holds the slot; release accepts requester 1 immediately.
    cycle(4'b0011, 1'b1);
    for (int j = 0; j < 3; j++) begin
      cycle(4'b0011, 1'b0);
      chk("d33_ready", 64'(ctrl_ready), 64'(0));
      chk("d33_outs", 64'(outs), 64'(32'h10));
    end
    cycle(4'b0011, 1'b1);
    chk("d33_accept1", 64'(ctrl_ready), 64'(4'b0010));
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);

    // Requester 1 withdraws while blocked: it must never be emitted.
    cycle(4'b0001, 1'b1);
    id1_seen = 0;
    cycle(4'b0010, 1'b0);
    cycle(4'b0010, 1'b0);
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);
    chk("d36_no_id1", 64'(id1_seen), 64'(0));

    // Reset while the slot is full and blocked.
    cycle(4'b0001, 1'b1);
    cycle(4'b0000, 1'b0);
    pulse_reset();
    cycle(4'b1000, 1'b1);
    cycle(4'b0000, 1'b1);
    chk("d35_id", 64'(outs_id), 64'(3));
    chk("d35_outs", 64'(outs), 64'(32'h13));
    cycle(4'b0000, 1'b1);

    // Random traffic, with valids sometimes held across cycles.
    begin
      logic [N-1:0] cv;
      cv = '0;
      for (int j = 0; j < 400; j++) begin
        if ($urandom_range(0, 2) != 0) cv = N'($urandom_range(0, 15));
        cycle(cv, $urandom_range(0, 3) != 0);
      end
    end
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);
    chk("sb_drained", 64'(exp_id_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/handshake_const_arbiter.md
HANDSHAKE_CONST_ARBITER -- requirements
Module: handshake_const_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the width of the constant output.
REQ-002 SHALL have parameter NUM_REQ, default 4, giving the number of requesters (2..16).
REQ-003 SHALL have parameter CONSTS, default 0, a flat NUM_REQ*DATA_WIDTH vector: slice i is requester i's constant.
REQ-004 SHALL define ID_W = max(1, clog2(NUM_REQ)) as a local parameter.
REQ-005 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1, the reset: asynchronous assertion, active-low.
REQ-007 SHALL have port ctrl_valid, input, NUM_REQ, per-requester token valid.
REQ-008 SHALL have port ctrl_ready, output, NUM_REQ, per-requester token accept.
REQ-009 SHALL have port outs, output, DATA_WIDTH, the registered constant of the served requester.
REQ-010 SHALL have port outs_id, output, ID_W, the index of the served requester.
REQ-011 SHALL have port outs_valid, output, 1, output slot full.
REQ-012 SHALL have port outs_ready, input, 1, downstream accept.

Function
REQ-013 SHALL hold one output slot (outs, outs_id, outs_valid) and a round-robin pointer ptr (ID_W bits).
REQ-014 SHALL compute slot_free = !outs_valid || outs_ready combinationally.
REQ-015 SHALL select winner w as the first i with ctrl_valid[i]=1, scanning ptr, ptr+1, ... modulo NUM_REQ.
REQ-016 SHALL drive ctrl_ready[w]=1 only when a winner exists and slot_free=1; all other ctrl_ready bits 0.
REQ-017 SHALL treat requester i as accepted when ctrl_valid[i] && ctrl_ready[i]; at most one accept per cycle.
REQ-018 SHALL, on accept, load outs <= CONSTS slice w, outs_id <= w, outs_valid <= 1, ptr <= (w+1) mod NUM_REQ on the next edge.
REQ-019 SHALL, when outs_valid && outs_ready and no accept, clear outs_valid next edge; outs and outs_id hold.
REQ-020 SHALL, when outs_valid && outs_ready and an accept coincide, replace the slot with no bubble (throughput 1 token/cycle).
REQ-021 SHALL hold the slot unchanged when outs_valid=1 and outs_ready=0; all ctrl_ready=0.
REQ-022 SHALL hold ptr when no accept occurs.
REQ-023 SHALL have latency 1 cycle from accept to outs_valid.
REQ-024 SHALL tolerate a ctrl_valid deasserted without handshake: re-arbitrate next cycle, no token emitted for it.
REQ-025 SHALL, for NUM_REQ not a power of two, never let ptr or w exceed NUM_REQ-1.
REQ-026 SHALL guarantee no requester waits more than NUM_REQ accepts while continuously valid.
REQ-027 SHALL have no combinational path from outs_ready to outs, outs_id or outs_valid.

Reset
REQ-028 SHALL, while rst=0, force outs_valid=0, outs=0, outs_id=0, ptr=0, immediately and asynchronously.
REQ-029 SHALL drive all ctrl_ready bits 0 while rst=0.
REQ-030 SHALL, on rst assertion mid-transfer, discard the slot token; first accept after release starts from ptr=0.

Verification (NUM_REQ=4, DATA_WIDTH=32, CONSTS slice i = 0x0000_0010+i)
REQ-031 SHALL cover: reset, then ctrl_valid=0b0100, outs_ready=1 -> ctrl_ready=0b0100 that cycle; next cycle outs=0x12, outs_id=2, outs_valid=1, ptr=3.
REQ-032 SHALL cover: ctrl_valid=0b1111 held, outs_ready=1 for 8 cycles -> outs_id sequence 0,1,2,3,0,1,2,3 with outs_valid continuously 1 after the first cycle.
REQ-033 SHALL cover: slot full, outs_ready=0 for 3 cycles with ctrl_valid=0b0011 -> ctrl_ready=0, outs=0x10 stable; on outs_ready=1, requester 1 accepted the same cycle.
REQ-034 SHALL cover: ptr=3, ctrl_valid=0b0001 -> requester 0 wins (wrap-around), ptr becomes 1.
REQ-035 SHALL cover: rst pulsed low while outs_valid=1 and outs_ready=0 -> outs_valid=0 without a clock edge; after release, ctrl_valid=0b1000 -> outs_id=3, outs=0x13.
REQ-036 SHALL cover: ctrl_valid[1] raised then dropped while slot blocked -> no token with outs_id=1 ever emitted.
